iob2axil: RTL and testbench

IOB2AXIL -- requirements
Module: iob2axil

---
 rtl/iob2axil.sv | 202 ++++++++++++++++++++
 tb/tb_iob2axil.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob2axil.sv
`default_nettype none
// ============================================================================
//  Module   : iob2axil
//  Purpose  : Bridges a single-outstanding IOb native request port onto an
//             AXI4-Lite master. A request with nonzero strobes becomes a
//             write (AW+W, then B); with zero strobes it becomes a read
//             (AR, then R) and the read data comes back as a one-cycle
//             iob_rvalid_o pulse.
//  Ports    : clk_i, cke_i (clock enable), arst_i (async, active-high)
//             iob_*   : IOb slave side (avalid/addr/wdata/wstrb in,
//                       ready/rvalid/rdata out)
//             axil_*  : AXI4-Lite master write (AW/W/B) and read (AR/R)
//             err_clr_i / err_o : sticky bus-error flag, only present
//                       when IOB2AXIL_ERR_EN is defined
//  Config   : `define IOB2AXIL_ERR_EN to add the sticky error flag
//  Revision : 1.0 - initial release
// ============================================================================
module iob2axil #(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     cke_i,
    input  logic                     arst_i,
    // IOb slave side
    input  logic                     iob_avalid_i,
    input  logic [ADDR_W-1:0]        iob_addr_i,
    input  logic [DATA_W-1:0]        iob_wdata_i,
    input  logic [DATA_W/8-1:0]      iob_wstrb_i,
    output logic                     iob_ready_o,
    output logic                     iob_rvalid_o,
    output logic [DATA_W-1:0]        iob_rdata_o,
`ifdef IOB2AXIL_ERR_EN
    input  logic                     err_clr_i,
    output logic                     err_o,
`endif
    // AXI4-Lite write channels
    output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
    output logic [2:0]               axil_awprot_o,
    output logic                     axil_awvalid_o,
    input  logic                     axil_awready_i,
    output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
    output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
    output logic                     axil_wvalid_o,
    input  logic                     axil_wready_i,
    input  logic [1:0]               axil_bresp_i,
    input  logic                     axil_bvalid_i,
    output logic                     axil_bready_o,
    // AXI4-Lite read channels
    output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
    output logic [2:0]               axil_arprot_o,
    output logic                     axil_arvalid_o,
    input  logic                     axil_arready_i,
    input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
    input  logic [1:0]               axil_rresp_i,
    input  logic                     axil_rvalid_i,
    output logic                     axil_rready_o
);

    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] c_WR_RESP      = 3'd2;
    localparam logic [2:0] c_RD_ADDR      = 3'd3;
    localparam logic [2:0] c_RD_DATA      = 3'd4;

    // Unprivileged, non-secure, data access
    localparam logic [2:0] c_PROT = 3'b010;

    logic [2:0]             state_q,   state_d;
    logic [AXIL_ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0]      wdata_q,   wdata_d;
    logic [DATA_W/8-1:0]    wstrb_q,   wstrb_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q,  wvalid_d;
    logic                   rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]      rdata_q,   rdata_d;

    logic accept;
    logic aw_done;
    logic w_done;

    assign accept  = iob_avalid_i & iob_ready_o;
    // A channel counts as done if it already handshook earlier or does so now
    assign aw_done = ~awvalid_q | axil_awready_i;
    assign w_done  = ~wvalid_q  | axil_wready_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= c_IDLE;
        end else if (cke_i) begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:         if (accept) state_d = (|iob_wstrb_i) ? c_WR_ADDR_DATA : c_RD_ADDR;
            c_WR_ADDR_DATA: if (aw_done && w_done) state_d = c_WR_RESP;
            c_WR_RESP:      if (axil_bvalid_i) state_d = c_IDLE;
            c_RD_ADDR:      if (axil_arready_i) state_d = c_RD_DATA;
            c_RD_DATA:      if (axil_rvalid_i) state_d = c_IDLE;
            default:        state_d = c_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (cke_i) begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        if (accept) begin
            addr_d  = AXIL_ADDR_W'(iob_addr_i);
            wdata_d = iob_wdata_i;
            wstrb_d = iob_wstrb_i;
            if (|iob_wstrb_i) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
            end
        end
        // AW and W retire independently; either may handshake first
        if (awvalid_q && axil_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && axil_wready_i)   wvalid_d  = 1'b0;
        rvalid_d = (state_q == c_RD_DATA) && axil_rvalid_i;
        rdata_d  = rvalid_d ? axil_rdata_i : rdata_q;
    end

    // ---------------- outputs ----------------
    always_comb begin
        // Held low while reset is asserted so nothing is accepted during reset
        iob_ready_o    = (state_q == c_IDLE) && !arst_i;
        axil_arvalid_o = (state_q == c_RD_ADDR);
        axil_rready_o  = (state_q == c_RD_DATA);
        axil_bready_o  = (state_q == c_WR_RESP);
    end

    assign iob_rvalid_o   = rvalid_q;
    assign iob_rdata_o    = rdata_q;
    assign axil_awaddr_o  = addr_q;
    assign axil_araddr_o  = addr_q;
    assign axil_awprot_o  = c_PROT;
    assign axil_arprot_o  = c_PROT;
    assign axil_awvalid_o = awvalid_q;
    assign axil_wvalid_o  = wvalid_q;
    assign axil_wdata_o   = wdata_q;
    assign axil_wstrb_o   = wstrb_q;

`ifdef IOB2AXIL_ERR_EN
    logic err_q, err_d, err_set;

    always_comb begin
        err_set = (axil_bvalid_i && axil_bready_o && (axil_bresp_i != 2'b00)) ||
                  (axil_rvalid_i && axil_rready_o && (axil_rresp_i != 2'b00));
        err_d = err_q;
        if (err_clr_i) err_d = 1'b0;
        // A new error in the same cycle as a clear must not be lost
        if (err_set)   err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q <= 1'b0;
        end else if (cke_i) begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    // Responses never affect flow control, so without the error flag they are unused
    logic unused_resp;
    assign unused_resp = ^{axil_bresp_i, axil_rresp_i};
`endif

endmodule
`default_nettype wire

// File: tb/tb_iob2axil.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iob2axil
//  Purpose  : Directed, table-driven bench for iob2axil with a small
//             AXI4-Lite slave whose per-channel ready/valid stalls come
//             from each vector. Hand sequences cover clock enable,
//             mid-transaction reset and the sticky error flag
//             (IOB2AXIL_ERR_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iob2axil;

    logic        clk = 1'b0;
    logic        cke_i, arst_i;
    logic        iob_avalid_i;
    logic [31:0] iob_addr_i, iob_wdata_i;
    logic [3:0]  iob_wstrb_i;
    logic        iob_ready_o, iob_rvalid_o;
    logic [31:0] iob_rdata_o;
    logic [31:0] axil_awaddr_o, axil_wdata_o, axil_araddr_o, axil_rdata_i;
    logic [2:0]  axil_awprot_o, axil_arprot_o;
    logic [3:0]  axil_wstrb_o;
    logic        axil_awvalid_o, axil_awready_i, axil_wvalid_o, axil_wready_i;
    logic [1:0]  axil_bresp_i, axil_rresp_i;
    logic        axil_bvalid_i, axil_bready_o;
    logic        axil_arvalid_o, axil_arready_i, axil_rvalid_i, axil_rready_o;
`ifdef IOB2AXIL_ERR_EN
    logic        err_clr_i, err_o;
`endif

    int          n_cmp, n_fail;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    iob2axil dut (
        .clk_i          (clk),
        .cke_i          (cke_i),
        .arst_i         (arst_i),
        .iob_avalid_i   (iob_avalid_i),
        .iob_addr_i     (iob_addr_i),
        .iob_wdata_i    (iob_wdata_i),
        .iob_wstrb_i    (iob_wstrb_i),
        .iob_ready_o    (iob_ready_o),
        .iob_rvalid_o   (iob_rvalid_o),
        .iob_rdata_o    (iob_rdata_o),
`ifdef IOB2AXIL_ERR_EN
        .err_clr_i      (err_clr_i),
        .err_o          (err_o),
`endif
        .axil_awaddr_o  (axil_awaddr_o),
        .axil_awprot_o  (axil_awprot_o),
        .axil_awvalid_o (axil_awvalid_o),
        .axil_awready_i (axil_awready_i),
        .axil_wdata_o   (axil_wdata_o),
        .axil_wstrb_o   (axil_wstrb_o),
        .axil_wvalid_o  (axil_wvalid_o),
        .axil_wready_i  (axil_wready_i),
        .axil_bresp_i   (axil_bresp_i),
        .axil_bvalid_i  (axil_bvalid_i),
        .axil_bready_o  (axil_bready_o),
        .axil_araddr_o  (axil_araddr_o),
        .axil_arprot_o  (axil_arprot_o),
        .axil_arvalid_o (axil_arvalid_o),
        .axil_arready_i (axil_arready_i),
        .axil_rdata_i   (axil_rdata_i),
        .axil_rresp_i   (axil_rresp_i),
        .axil_rvalid_i  (axil_rvalid_i),
        .axil_rready_o  (axil_rready_o)
    );

    // s0: AR (read) / AW (write) ready stall; s1: R / W stall; s2: B stall
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          s0, s1, s2;
        logic        clr;
        int          lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [31:0] rdata, input logic [1:0] resp,
                                input int s0, input int s1, input int s2, input logic clr,
                                input int lat, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.rdata = rdata;
        v.resp = resp; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.clr = clr; v.lat = lat;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_slave();
        axil_arready_i = 1'b0; axil_awready_i = 1'b0; axil_wready_i = 1'b0;
        axil_rvalid_i  = 1'b0; axil_bvalid_i  = 1'b0;
        axil_rresp_i   = 2'b00; axil_bresp_i  = 2'b00; axil_rdata_i = 32'h0;
`ifdef IOB2AXIL_ERR_EN
        err_clr_i = 1'b0;
`endif
    endtask

    // Called and returns on a falling edge; the next request may be issued
    // in the same cycle the previous one completes.
    task automatic run_txn(input vec_t v);
        int   cyc, c0, c1, c2;
        logic done;
        logic p_ar, p_arr, p_aw, p_awr, p_w, p_wr;
        cyc = 0; c0 = 0; c1 = 0; c2 = 0; done = 1'b0;
        p_ar = 1'b0; p_arr = 1'b0; p_aw = 1'b0; p_awr = 1'b0; p_w = 1'b0; p_wr = 1'b0;
        chk("issue_ready", 32'(iob_ready_o), 32'd1);
        iob_avalid_i = 1'b1;
        iob_addr_i   = v.addr;
        iob_wdata_i  = v.wdata;
        iob_wstrb_i  = v.wr ? v.wstrb : 4'h0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            iob_avalid_i = 1'b0;
            iob_addr_i   = ~v.addr;
            iob_wdata_i  = ~v.wdata;
            iob_wstrb_i  = 4'hF;
            if (p_ar) chk("arvalid_hold", 32'(axil_arvalid_o), 32'(!p_arr));
            if (p_aw) chk("awvalid_hold", 32'(axil_awvalid_o), 32'(!p_awr));
            if (p_w)  chk("wvalid_hold",  32'(axil_wvalid_o),  32'(!p_wr));
            if (cyc == 1) begin
                if (v.wr) chk("aw_w_first", 32'({axil_awvalid_o, axil_wvalid_o}), 32'd3);
                else      chk("ar_first", 32'(axil_arvalid_o), 32'd1);
            end
            if (axil_arvalid_o) begin
                chk("araddr", axil_araddr_o, v.addr);
                chk("arprot", 32'(axil_arprot_o), 32'd2);
            end
            if (axil_awvalid_o) begin
                chk("awaddr", axil_awaddr_o, v.addr);
                chk("awprot", 32'(axil_awprot_o), 32'd2);
            end
            if (axil_wvalid_o) begin
                chk("wdata", axil_wdata_o, v.wdata);
                chk("wstrb", 32'(axil_wstrb_o), 32'(v.wstrb));
            end
            if (v.wr) chk("no_rd_chan", 32'({axil_arvalid_o, axil_rready_o, iob_rvalid_o}), 32'd0);
            else      chk("no_wr_chan", 32'({axil_awvalid_o, axil_wvalid_o, axil_bready_o}), 32'd0);
            done = v.wr ? iob_ready_o : iob_rvalid_o;
            if (done) begin
                chk("latency", 32'(cyc), 32'(v.lat));
                chk("ready_at_end", 32'(iob_ready_o), 32'd1);
                if (!v.wr) begin
                    chk("rdata", iob_rdata_o, v.exp_rdata);
                    last_rdata = v.exp_rdata;
                end
`ifdef IOB2AXIL_ERR_EN
                chk("err", 32'(err_o), 32'(v.exp_err));
`endif
                clr_slave();
            end else if (cyc >= 40) begin
                n_cmp++; n_fail++;
                $display("FAIL txn_timeout: got %0d cycles without completion, expected %0d", cyc, v.lat);
                done = 1'b1;
                clr_slave();
            end else begin
                chk("ready_busy", 32'(iob_ready_o), 32'd0);
                chk("rdata_hold", iob_rdata_o, last_rdata);
                p_ar = axil_arvalid_o; p_aw = axil_awvalid_o; p_w = axil_wvalid_o;
                axil_arready_i = axil_arvalid_o && (c0 >= v.s0);
                axil_awready_i = axil_awvalid_o && (c0 >= v.s0);
                if (axil_arvalid_o || axil_awvalid_o) c0++;
                axil_wready_i  = axil_wvalid_o && (c1 >= v.s1);
                axil_rvalid_i  = axil_rready_o && (c1 >= v.s1);
                if (axil_wvalid_o || axil_rready_o) c1++;
                axil_bvalid_i  = axil_bready_o && (c2 >= v.s2);
                if (axil_bready_o) c2++;
                p_arr = axil_arready_i; p_awr = axil_awready_i; p_wr = axil_wready_i;
                axil_rdata_i = axil_rvalid_i ? v.rdata : ~v.rdata;
                axil_rresp_i = axil_rvalid_i ? v.resp : 2'b00;
                axil_bresp_i = axil_bvalid_i ? v.resp : 2'b00;
`ifdef IOB2AXIL_ERR_EN
                err_clr_i = (axil_rvalid_i || axil_bvalid_i) && v.clr;
`endif
            end
        end
    endtask

    // Request presented with the clock disabled must not be taken
    task automatic cke_seq();
        cke_i = 1'b0;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h80; iob_wstrb_i = 4'h0;
        repeat (3) begin
            @(negedge clk);
            chk("cke_ready", 32'(iob_ready_o), 32'd1);
            chk("cke_no_ar", 32'(axil_arvalid_o), 32'd0);
        end
        iob_avalid_i = 1'b0; cke_i = 1'b1;
        @(negedge clk);
        chk("cke_idle", 32'(axil_arvalid_o), 32'd0);
    endtask

    // Reset asserted while the bridge waits in the write-response state
    task automatic rst_mid_write();
        int k;
        k = 0;
        chk("rstw_issue_ready", 32'(iob_ready_o), 32'd1);
        iob_avalid_i = 1'b1; iob_addr_i = 32'h40; iob_wdata_i = 32'h77; iob_wstrb_i = 4'hF;
        do begin
            @(negedge clk);
            iob_avalid_i = 1'b0;
            axil_awready_i = axil_awvalid_o;
            axil_wready_i  = axil_wvalid_o;
            k++;
        end while (!axil_bready_o && k < 10);
        chk("rstw_in_wr_resp", 32'(axil_bready_o), 32'd1);
        clr_slave();
        arst_i = 1'b1;
        #1;
        chk("rstw_outs_zero", 32'({axil_awvalid_o, axil_wvalid_o, axil_bready_o,
                                  axil_arvalid_o, axil_rready_o, iob_rvalid_o}), 32'd0);
        chk("rstw_rdata_zero", iob_rdata_o, 32'd0);
        @(negedge clk);
        chk("rstw_outs_held", 32'({axil_awvalid_o, axil_wvalid_o, axil_bready_o,
                                  axil_arvalid_o, axil_rready_o, iob_rvalid_o}), 32'd0);
        arst_i = 1'b0;
        last_rdata = 32'h0;
        #1;
        chk("rstw_release_ready", 32'(iob_ready_o), 32'd1);
        @(negedge clk);
        chk("rstw_idle_ready", 32'(iob_ready_o), 32'd1);
        chk("rstw_no_resume", 32'({axil_awvalid_o, axil_wvalid_o, axil_bready_o}), 32'd0);
    endtask

`ifdef IOB2AXIL_ERR_EN
    task automatic err_clear_seq();
        chk("err_set", 32'(err_o), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("err_sticky", 32'(err_o), 32'd1);
        end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("err_cleared", 32'(err_o), 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, expected earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; last_rdata = 32'h0;
        //              wr addr          wdata         strb  rdata         resp  s0 s1 s2 clr lat exp_rdata     err
        vecs[0] = mk(0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 3, 32'hDEADBEEF, 0);
        vecs[1] = mk(1, 32'h0000_0200, 32'h12345678, 4'hF, 32'h0,        2'b00, 0, 1, 0, 0, 4, 32'h0,        0);
        vecs[2] = mk(0, 32'h0000_0104, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 5, 0, 0, 0, 8, 32'hCAFEF00D, 0);
        vecs[3] = mk(0, 32'h0000_03FC, 32'h0,        4'h0, 32'h000000A5, 2'b00, 0, 2, 0, 0, 5, 32'h000000A5, 0);
        vecs[4] = mk(1, 32'hFFFF_FFFC, 32'hA5A5A5A5, 4'h1, 32'h0,        2'b00, 1, 0, 2, 0, 6, 32'h0,        0);
        vecs[5] = mk(1, 32'h0000_0010, 32'h0,        4'h8, 32'h0,        2'b00, 0, 0, 0, 0, 3, 32'h0,        0);
        vecs[6] = mk(0, 32'h0000_0020, 32'h0,        4'h0, 32'h11223344, 2'b10, 0, 0, 0, 0, 3, 32'h11223344, 1);
        vecs[7] = mk(1, 32'h0000_0024, 32'h55AA55AA, 4'h6, 32'h0,        2'b11, 0, 0, 0, 1, 3, 32'h0,        1);
        vecs[8] = mk(0, 32'h0000_0028, 32'h0,        4'h0, 32'h0BADF00D, 2'b00, 0, 0, 0, 1, 3, 32'h0BADF00D, 0);
        vecs[9] = mk(0, 32'h0000_0044, 32'h0,        4'h0, 32'h600DCAFE, 2'b00, 0, 1, 0, 0, 4, 32'h600DCAFE, 0);

        arst_i = 1'b1; cke_i = 1'b1;
        iob_avalid_i = 1'b0; iob_addr_i = 32'h0; iob_wdata_i = 32'h0; iob_wstrb_i = 4'h0;
        clr_slave();
        repeat (2) @(negedge clk);
        chk("rst_outs_zero", 32'({axil_awvalid_o, axil_wvalid_o, axil_bready_o,
                                 axil_arvalid_o, axil_rready_o, iob_rvalid_o}), 32'd0);
        chk("rst_rdata_zero", iob_rdata_o, 32'd0);
`ifdef IOB2AXIL_ERR_EN
        chk("rst_err_zero", 32'(err_o), 32'd0);
`endif
        arst_i = 1'b0;
        #1;
        chk("rst_release_ready", 32'(iob_ready_o), 32'd1);
        @(negedge clk);

        cke_seq();
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);
`ifdef IOB2AXIL_ERR_EN
        err_clear_seq();
`endif
        for (int i = 7; i < 9; i++) run_txn(vecs[i]);
        rst_mid_write();
        run_txn(vecs[9]);
        repeat (2) @(negedge clk);
        chk("final_rdata_hold", iob_rdata_o, 32'h600DCAFE);
        chk("final_no_rvalid", 32'(iob_rvalid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
